// File: rtl/bldc_pkg.sv
// Shared types and helpers for the BLDC Hall-sensor front end.
//   hall_state_t   : decoder FSM states
//   sector_t       : commutation sector index 0..5
//   hall_decode_t  : {legal, sector} result of a Hall code lookup
//   hall_to_sector : maps a {C,B,A} Hall code to its sector, flagging 000/111 as illegal
//   sector_inc/dec : modulo-6 neighbours of a sector
package bldc_pkg;

   typedef enum logic [1:0] {
      HS_INIT   = 2'd0,
      HS_LOCKED = 2'd1,
      HS_FAULT  = 2'd2
   } hall_state_t;

   typedef logic [2:0] sector_t;

   localparam int NUM_SECTORS = 6;

   typedef struct packed {
      logic    legal;
      sector_t sector;
   } hall_decode_t;

   function automatic hall_decode_t hall_to_sector(input logic [2:0] code);
      hall_decode_t d;
      d.legal  = 1'b1;
      d.sector = '0;
      case (code)
         3'b001:  d.sector = 3'd0;
         3'b011:  d.sector = 3'd1;
         3'b010:  d.sector = 3'd2;
         3'b110:  d.sector = 3'd3;
         3'b100:  d.sector = 3'd4;
         3'b101:  d.sector = 3'd5;
         default: d.legal  = 1'b0;
      endcase
      return d;
   endfunction

   function automatic sector_t sector_inc(input sector_t s);
      return (s == sector_t'(NUM_SECTORS - 1)) ? sector_t'(0) : s + sector_t'(1);
   endfunction

   function automatic sector_t sector_dec(input sector_t s);
      return (s == sector_t'(0)) ? sector_t'(NUM_SECTORS - 1) : s - sector_t'(1);
   endfunction

endpackage

// File: rtl/hall_glitch_filter.sv
// Hall input conditioning: 2-FF synchronizer followed by a stability filter.
// A synchronized code must hold for FILTER_CYCLES consecutive samples and differ
// from the previously accepted code before it is accepted.
//   clk, reset : system clock, asynchronous active-high reset
//   hall_in    : raw Hall inputs {C,B,A}, asynchronous to clk
//   code       : last accepted Hall code
//   accept     : one-cycle strobe coincident with a new value on code
module hall_glitch_filter
   import bldc_pkg::*;
#(
   parameter int FILTER_CYCLES = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] hall_in,
   output logic [2:0] code,
   output logic       accept
);

   localparam logic [7:0] CNT_MAX = 8'(FILTER_CYCLES - 1);

   logic [2:0] sync_p0;
   logic [2:0] sync_p1;
   logic [2:0] cand_p2;
   logic [7:0] cnt;
   logic [7:0] cnt_nxt;

   // The count tracks how many samples after the first one the candidate has
   // held, saturating so a long stable code cannot wrap and re-trigger.
   always_comb begin
      if (sync_p1 != cand_p2)
         cnt_nxt = '0;
      else if (cnt == CNT_MAX)
         cnt_nxt = cnt;
      else
         cnt_nxt = cnt + 8'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
         cand_p2 <= '0;
         cnt     <= '0;
         code    <= '0;
         accept  <= 1'b0;
      end else begin
         // stage p0/p1: metastability synchronizer
         sync_p0 <= hall_in;
         sync_p1 <= sync_p0;
         // stage p2: candidate and stability count
         cand_p2 <= sync_p1;
         cnt     <= cnt_nxt;
         // accept stage: sync_p1 is the candidate value after this edge
         accept  <= 1'b0;
         if ((cnt_nxt == CNT_MAX) && (sync_p1 != code)) begin
            accept <= 1'b1;
            code   <= sync_p1;
         end
      end
   end

endmodule

// File: rtl/hall_state_decoder.sv
// BLDC Hall state decoder: conditions the Hall inputs, tracks the commutation
// sector and emits one state_change pulse per legal adjacent-sector step.
// Optional feature macro: HALL_ERR_COUNT_EN adds the err_count port/counter.
//   clk, reset   : system clock, asynchronous active-high reset
//   hall_in      : raw Hall inputs {C,B,A}
//   state_change : one-cycle pulse per adjacent step (feeds the period timer tick)
//   direction    : 1 = forward (sector+1), 0 = reverse; held between steps
//   sector       : current sector 0..5
//   valid        : sector reflects a legal accepted code
//   illegal      : one-cycle pulse on an illegal code or skipped sector
//   err_count    : saturating count of illegal pulses (HALL_ERR_COUNT_EN only)
module hall_state_decoder
   import bldc_pkg::*;
#(
   parameter int FILTER_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  hall_in,
   output logic        state_change,
   output logic        direction,
   output sector_t     sector,
   output logic        valid,
   output logic        illegal
`ifdef HALL_ERR_COUNT_EN
   ,
   output logic [15:0] err_count
`endif
);

   logic [2:0]   acc_code;
   logic         acc_stb;
   hall_decode_t dec;

   hall_state_t state;
   hall_state_t state_nxt;
   sector_t     sector_nxt;
   logic        dir_nxt;
   logic        valid_nxt;
   logic        chg_nxt;
   logic        ill_nxt;

   hall_glitch_filter #(
      .FILTER_CYCLES (FILTER_CYCLES)
   ) u_filter (
      .clk     (clk),
      .reset   (reset),
      .hall_in (hall_in),
      .code    (acc_code),
      .accept  (acc_stb)
   );

   assign dec = hall_to_sector(acc_code);

   always_comb begin
      state_nxt  = state;
      sector_nxt = sector;
      dir_nxt    = direction;
      valid_nxt  = valid;
      chg_nxt    = 1'b0;
      ill_nxt    = 1'b0;
      if (acc_stb) begin
         case (state)
            HS_INIT: begin
               if (dec.legal) begin
                  state_nxt  = HS_LOCKED;
                  sector_nxt = dec.sector;
                  valid_nxt  = 1'b1;
               end else begin
                  state_nxt = HS_FAULT;
                  ill_nxt   = 1'b1;
               end
            end
            HS_LOCKED: begin
               if (!dec.legal) begin
                  state_nxt = HS_FAULT;
                  valid_nxt = 1'b0;
                  ill_nxt   = 1'b1;
               end else if (dec.sector == sector_inc(sector)) begin
                  sector_nxt = dec.sector;
                  dir_nxt    = 1'b1;
                  chg_nxt    = 1'b1;
               end else if (dec.sector == sector_dec(sector)) begin
                  sector_nxt = dec.sector;
                  dir_nxt    = 1'b0;
                  chg_nxt    = 1'b1;
               end else if (dec.sector != sector) begin
                  // skipped sector: follow the rotor but flag the lost step
                  sector_nxt = dec.sector;
                  ill_nxt    = 1'b1;
               end
            end
            HS_FAULT: begin
               // resync only; a further illegal code stays silent
               if (dec.legal) begin
                  state_nxt  = HS_LOCKED;
                  sector_nxt = dec.sector;
                  valid_nxt  = 1'b1;
               end
            end
            default: state_nxt = HS_INIT;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= HS_INIT;
         sector       <= '0;
         direction    <= 1'b1;
         valid        <= 1'b0;
         state_change <= 1'b0;
         illegal      <= 1'b0;
      end else begin
         state        <= state_nxt;
         sector       <= sector_nxt;
         direction    <= dir_nxt;
         valid        <= valid_nxt;
         state_change <= chg_nxt;
         illegal      <= ill_nxt;
      end
   end

`ifdef HALL_ERR_COUNT_EN
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         err_count <= '0;
      else if (ill_nxt)
         err_count <= sat_inc16(err_count);
   end
`endif

endmodule

// File: tb/tb_hall_state_decoder.sv
// Self-checking bench for hall_state_decoder: directed scenarios followed by
// randomized Hall sequences, all compared cycle by cycle against a
// sample-history reference model.
module tb_hall_state_decoder;

   localparam int F = 16;

   logic       clk;
   logic       reset;
   logic [2:0] hall_in;
   logic       state_change;
   logic       direction;
   logic [2:0] sector;
   logic       valid;
   logic       illegal;
`ifdef HALL_ERR_COUNT_EN
   logic [15:0] err_count;
`endif

   hall_state_decoder #(.FILTER_CYCLES(F)) dut (
      .clk          (clk),
      .reset        (reset),
      .hall_in      (hall_in),
      .state_change (state_change),
      .direction    (direction),
      .sector       (sector),
      .valid        (valid),
      .illegal      (illegal)
`ifdef HALL_ERR_COUNT_EN
      ,
      .err_count    (err_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      else
         n_pass++;
   endtask

   // ---------------- reference model ----------------
   logic [2:0] CODE_OF [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

   logic [2:0] hist [$];
   logic [2:0] m_acc;
   int         m_mode;     // 0 = not yet locked, 1 = locked, 2 = faulted
   int         m_sector;
   bit         m_dir, m_valid, m_chg, m_ill;
   int         m_err;

   function automatic int sector_of(input logic [2:0] c);
      for (int i = 0; i < 6; i++)
         if (CODE_OF[i] == c) return i;
      return -1;
   endfunction

   task automatic model_reset();
      hist.delete();
      for (int i = 0; i < F + 3; i++) hist.push_back(3'b000);
      m_acc = 3'b000; m_mode = 0; m_sector = 0;
      m_dir = 1'b1; m_valid = 1'b0; m_chg = 1'b0; m_ill = 1'b0; m_err = 0;
   endtask

   // One clock edge: h is the Hall value seen at this edge.  A code takes
   // effect at the outputs three edges after its F-th consecutive sample.
   task automatic model_edge(input logic [2:0] h);
      bit         ev;
      logic [2:0] c;
      int         s, d;
      if (reset) begin
         model_reset();
         return;
      end
      hist.push_back(h);
      if (hist.size() > F + 3) void'(hist.pop_front());
      m_chg = 1'b0;
      m_ill = 1'b0;
      c  = hist[0];
      ev = (c != m_acc);
      for (int i = 1; i < F; i++)
         if (hist[i] != c) ev = 1'b0;
      if (ev) begin
         m_acc = c;
         s = sector_of(c);
         if (m_mode == 1) begin
            if (s < 0) begin
               m_mode = 2; m_valid = 1'b0; m_ill = 1'b1;
            end else begin
               d = (s - m_sector + 6) % 6;
               if (d == 1) begin m_chg = 1'b1; m_dir = 1'b1; end
               else if (d == 5) begin m_chg = 1'b1; m_dir = 1'b0; end
               else if (d != 0) m_ill = 1'b1;
               m_sector = s;
            end
         end else begin
            if (s >= 0) begin
               m_mode = 1; m_sector = s; m_valid = 1'b1;
            end else if (m_mode == 0) begin
               m_mode = 2; m_ill = 1'b1;
            end
         end
         if (m_ill && m_err < 65535) m_err++;
      end
   endtask

   task automatic compare_all();
      chk("state_change", 32'(state_change), 32'(m_chg));
      chk("illegal",      32'(illegal),      32'(m_ill));
      chk("sector",       32'(sector),       32'(m_sector));
      chk("valid",        32'(valid),        32'(m_valid));
      chk("direction",    32'(direction),    32'(m_dir));
`ifdef HALL_ERR_COUNT_EN
      chk("err_count",    32'(err_count),    32'(m_err));
`endif
   endtask

   // ---------------- stimulus helpers ----------------
   int h_chg, h_ill, h_first_chg, h_first_valid;

   task automatic tick(input logic [2:0] h);
      hall_in = h;
      @(posedge clk);
      model_edge(h);
      #1;
      compare_all();
   endtask

   task automatic hold(input logic [2:0] c, input int n);
      h_chg = 0; h_ill = 0; h_first_chg = 0; h_first_valid = 0;
      for (int i = 1; i <= n; i++) begin
         tick(c);
         if (state_change) begin
            h_chg++;
            if (h_first_chg == 0) h_first_chg = i;
         end
         if (illegal) h_ill++;
         if (valid && h_first_valid == 0) h_first_valid = i;
      end
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_state_change"}, 32'(state_change), 32'd0);
      chk({tag, "_direction"},    32'(direction),    32'd1);
      chk({tag, "_sector"},       32'(sector),       32'd0);
      chk({tag, "_valid"},        32'(valid),        32'd0);
      chk({tag, "_illegal"},      32'(illegal),      32'd0);
`ifdef HALL_ERR_COUNT_EN
      chk({tag, "_err_count"},    32'(err_count),    32'd0);
`endif
   endtask

   logic [2:0] fwd_seq [6] = '{3'b011, 3'b010, 3'b110, 3'b100, 3'b101, 3'b001};

   initial begin
      int         cur_s, r, len;
      logic [2:0] nc;

      reset   = 1'b1;
      hall_in = 3'b001;
      #1;
      check_reset_values("reset");
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // 1: lock on first legal code, no step pulse
      hold(3'b001, 40);
      chk("t1_lock_edge", 32'(h_first_valid), 32'd19);
      chk("t1_pulses",    32'(h_chg),         32'd0);
      chk("t1_sector",    32'(sector),        32'd0);

      // 2: full forward revolution including 5->0 wrap
      for (int k = 0; k < 6; k++) begin
         hold(fwd_seq[k], 50);
         chk("t2_pulses",  32'(h_chg),       32'd1);
         chk("t2_latency", 32'(h_first_chg), 32'd19);
         chk("t2_illegal", 32'(h_ill),       32'd0);
         chk("t2_dir",     32'(direction),   32'd1);
         chk("t2_sector",  32'(sector),      32'((k + 1) % 6));
      end

      // 3: reverse from sector 2
      hold(3'b011, 50);
      hold(3'b010, 50);
      hold(3'b011, 50);
      chk("t3_pulse1",  32'(h_chg),     32'd1);
      chk("t3_dir1",    32'(direction), 32'd0);
      chk("t3_sector1", 32'(sector),    32'd1);
      hold(3'b001, 50);
      chk("t3_pulse2",  32'(h_chg),     32'd1);
      chk("t3_dir2",    32'(direction), 32'd0);
      chk("t3_sector2", 32'(sector),    32'd0);

      // 4: a 15-cycle glitch is rejected
      hold(3'b011, 15);
      chk("t4_glitch_pulse", 32'(h_chg), 32'd0);
      hold(3'b001, 40);
      chk("t4_pulses", 32'(h_chg),  32'd0);
      chk("t4_sector", 32'(sector), 32'd0);

      // 5: illegal code, then resync
      hold(3'b111, 40);
      chk("t5_illegal", 32'(h_ill), 32'd1);
      chk("t5_valid",   32'(valid), 32'd0);
`ifdef HALL_ERR_COUNT_EN
      chk("t5_err_count", 32'(err_count), 32'd1);
`endif
      hold(3'b010, 40);
      chk("t5_resync_valid",  32'(valid),  32'd1);
      chk("t5_resync_sector", 32'(sector), 32'd2);
      chk("t5_resync_pulse",  32'(h_chg),  32'd0);
      chk("t5_resync_ill",    32'(h_ill),  32'd0);

      // 6: skipped sector, then reset mid filter window
      hold(3'b011, 40);
      hold(3'b001, 40);
      hold(3'b010, 40);
      chk("t6_skip_ill",    32'(h_ill),     32'd1);
      chk("t6_skip_pulse",  32'(h_chg),     32'd0);
      chk("t6_skip_sector", 32'(sector),    32'd2);
      chk("t6_skip_dir",    32'(direction), 32'd0);
      hold(3'b001, 8);
      #3;
      reset = 1'b1;
      #1;
      check_reset_values("t6_async");
      model_reset();
      tick(3'b001);
      tick(3'b001);
      reset = 1'b0;
      hold(3'b001, 40);
      chk("t6_post_pulse", 32'(h_chg), 32'd0);
      chk("t6_post_ill",   32'(h_ill), 32'd0);

      // randomized sequences: mostly adjacent steps with skips, illegal codes and glitches
      cur_s = 0;
      for (int seg = 0; seg < 200; seg++) begin
         r = int'($urandom_range(0, 9));
         if (cur_s < 0 || r == 9)
            nc = 3'($urandom_range(0, 7));
         else if (r <= 3)
            nc = CODE_OF[(cur_s + 1) % 6];
         else if (r <= 6)
            nc = CODE_OF[(cur_s + 5) % 6];
         else if (r == 7)
            nc = CODE_OF[(cur_s + 2 + int'($urandom_range(0, 2))) % 6];
         else
            nc = ($urandom_range(0, 1) == 1) ? 3'b111 : 3'b000;
         cur_s = sector_of(nc);
         if ($urandom_range(0, 4) == 0)
            len = int'($urandom_range(1, F));
         else
            len = int'($urandom_range(F, F + 25));
         hold(nc, len);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
